dram_ctrl: RTL
==============

// Module: dram_ctrl
// PURPOSE
//  Sequencing controller in front of dram_dut. Accepts single read/write requests
//  from one host over a valid/ready handshake, generates periodic refresh, and
//  arbitrates between them (refresh wins). Drives the dram_dut wren/refresh/addr/d_in
//  pins and captures d_out.
// PARAMETERS
//  ADDR_W     6   address width, matches dram_dut addr
//  DATA_W     8   data width, matches dram_dut d_in/d_out
//  REF_PERIOD 64  cycles between refresh requests; legal range > REF_CYCLES+RD_LAT+3
//  REF_CYCLES 4   cycles mem_refresh is held per refresh (>=1)
//  RD_LAT     1   cycles mem_addr is held before mem_dout is sampled (>=1)
//  REF_CNT_W  8   width of completed-refresh counter
// PORTS
//  clk        in  1          clock, all logic on posedge
//  rst        in  1          async active-high reset
//  req_valid  in  1          host request valid
//  req_ready  out 1          controller can accept request this cycle
//  req_we     in  1          1=write, 0=read
//  req_addr   in  ADDR_W     request address
//  req_wdata  in  DATA_W     write data
//  rsp_valid  out 1          one-cycle pulse: read data valid
//  rsp_rdata  out DATA_W     read data, held until next read completes
//  mem_wren   out 1          to dram_dut wren
//  mem_refresh out 1         to dram_dut refresh
//  mem_addr   out ADDR_W     to dram_dut addr
//  mem_din    out DATA_W     to dram_dut d_in
//  mem_dout   in  DATA_W     from dram_dut d_out
//  ref_cnt    out REF_CNT_W  completed refreshes, wraps at 2^REF_CNT_W
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, ref_pend=0, timer=REF_PERIOD-1, all
//   registered outputs 0 (incl. rsp_rdata, ref_cnt); req_ready=0 while rst high.
//  All mem_* outputs and rsp_* are registered. req_ready = !rst && state==IDLE && !ref_pend.
//  Refresh timer: free-running down-counter; at 0 reloads REF_PERIOD-1 and sets
//   ref_pend next cycle. ref_pend cleared when REFRESH is entered.
//  FSM: IDLE, WRITE, READ, REFRESH.
//   IDLE: ref_pend -> REFRESH; else req_valid&&req_ready -> WRITE (req_we=1) or READ;
//    request fields latched on handshake cycle T. mem_* = 0 in IDLE.
//   WRITE: exactly 1 cycle (T+1): mem_wren=1, mem_addr/mem_din = latched. -> IDLE.
//   READ: RD_LAT cycles (T+1..T+RD_LAT): mem_wren=0, mem_addr=latched; mem_dout
//    sampled at end of T+RD_LAT into rsp_rdata; rsp_valid=1 at T+RD_LAT+1 only. -> IDLE.
//   REFRESH: mem_refresh=1 for REF_CYCLES cycles, mem_wren=0, mem_addr=0; on exit
//    ref_cnt+=1 (mod 2^REF_CNT_W). -> IDLE.
//  Throughput: write every 2 cycles; read every RD_LAT+1 cycles (rsp_valid of read N
//   coincides with IDLE cycle able to accept N+1).
//  mem_wren and mem_refresh never high in the same cycle.
//  Simultaneous: timer hits 0 in handshake cycle T -> request accepted and executed;
//   refresh starts first IDLE cycle after it. Requests never dropped; req_valid held
//   by host while req_ready=0.
//  Timer runs in every state; refresh deferred by at most one access.
//  Reset mid-operation: access/refresh aborted, no rsp_valid, timer restarts full.
// TESTING
//  1 Reset: rst=1 mid-stream -> all outputs 0 same cycle, req_ready=0; release ->
//    req_ready=1, first mem_refresh after REF_PERIOD+1 cycles.
//  2 Write 0xA5@3 then read @3 (RD_LAT=1) -> mem_wren=1 one cycle addr 3 din 0xA5;
//    read handshake at T -> rsp_valid at T+2 with rsp_rdata=0xA5.
//  3 Idle, defaults -> mem_refresh high exactly 4 cycles every 64 cycles; ref_cnt
//    increments by 1 per burst.
//  4 Back-to-back reads with req_valid held high across a refresh -> req_ready low
//    during ref_pend+REFRESH, every issued address gets exactly one rsp_valid, in order.
//  5 Timer expiry in handshake cycle of a write -> write completes, refresh follows
//    next IDLE cycle; scoreboard data matches.
//  6 REF_CNT_W=2, run 5 refreshes -> ref_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/dram_ctrl.sv
// Sequencing controller in front of dram_dut: single host read/write requests over
// valid/ready, periodic refresh with priority over accesses, fully registered pins.
module dram_ctrl #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int REF_PERIOD = 64,
    parameter int REF_CYCLES = 4,
    parameter int RD_LAT     = 1,
    parameter int REF_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 rsp_valid,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 mem_wren,
    output logic                 mem_refresh,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_din,
    input  logic [DATA_W-1:0]    mem_dout,
    output logic [REF_CNT_W-1:0] ref_cnt
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WRITE   = 2'd1;
    localparam logic [1:0] S_READ    = 2'd2;
    localparam logic [1:0] S_REFRESH = 2'd3;

    localparam int TMR_W   = $clog2(REF_PERIOD);
    localparam int CNT_MAX = (REF_CYCLES > RD_LAT) ? REF_CYCLES : RD_LAT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REF_PERIOD - 1);
    localparam logic [CNT_W-1:0] REF_LAST   = CNT_W'(REF_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_LAT - 1);

    logic [1:0]       r_state;
    logic             r_ref_pend;
    logic [TMR_W-1:0] r_timer;
    logic [CNT_W-1:0] r_cnt;
    logic             w_hs;

    assign req_ready = !rst && (r_state == S_IDLE) && !r_ref_pend;
    assign w_hs      = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= TMR_RELOAD;
        end else if (r_timer == '0) begin
            r_timer <= TMR_RELOAD;
        end else begin
            r_timer <= r_timer - TMR_W'(1);
        end
    end

    // A fresh expiry takes priority over the clear so no refresh is ever lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_pend <= 1'b0;
        end else if (r_timer == '0) begin
            r_ref_pend <= 1'b1;
        end else if (r_state == S_IDLE && r_ref_pend) begin
            r_ref_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            mem_wren    <= 1'b0;
            mem_refresh <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            ref_cnt     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_ref_pend) begin
                        r_state     <= S_REFRESH;
                        mem_refresh <= 1'b1;
                        r_cnt       <= REF_LAST;
                    end else if (w_hs) begin
                        mem_addr <= req_addr;
                        if (req_we) begin
                            r_state  <= S_WRITE;
                            mem_wren <= 1'b1;
                            mem_din  <= req_wdata;
                        end else begin
                            r_state <= S_READ;
                            r_cnt   <= RD_LAST;
                        end
                    end
                end
                S_WRITE: begin
                    r_state  <= S_IDLE;
                    mem_wren <= 1'b0;
                    mem_addr <= '0;
                    mem_din  <= '0;
                end
                S_READ: begin
                    if (r_cnt == '0) begin
                        r_state   <= S_IDLE;
                        mem_addr  <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= mem_dout;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_REFRESH: begin
                    if (r_cnt == '0) begin
                        r_state     <= S_IDLE;
                        mem_refresh <= 1'b0;
                        ref_cnt     <= ref_cnt + REF_CNT_W'(1);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
